// File: rtl/imem_loader_if.sv
// imem_loader_if: load control, program byte stream and instruction-memory write bus
interface imem_loader_if #(parameter int ADDR_W = 9);
    logic              load_start;
    logic [9:0]        prog_len;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic [ADDR_W-1:0] addr;
    logic              wEn;
    logic [31:0]       wDat;
    logic              working;
    logic              busy;
    logic              err;
    modport master (
        output load_start, prog_len, in_valid, in_byte,
        input  in_ready, addr, wEn, wDat, working, busy, err
    );
    modport slave (
        input  load_start, prog_len, in_valid, in_byte,
        output in_ready, addr, wEn, wDat, working, busy, err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit words, writes them to
// instruction memory, then enables the processor once the whole program is in place.
module imem_loader #(
    parameter int ADDR_W    = 9,
    parameter int MAX_WORDS = 512
) (
    input  logic         clock,
    input  logic         rst_n,
    imem_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, RUN} state_t;
    localparam logic [10:0] MAX_L = 11'(MAX_WORDS);
    state_t            state_q, state_d;
    logic [9:0]        len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d, addr_q, addr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       word_q, word_d, wdat_q, wdat_d;
    logic              err_q, err_d;
    logic              in_ready_q, wen_q, working_q, busy_q;
    logic              legal, accept, last;
    assign legal  = bus.prog_len != '0 && {1'b0, bus.prog_len} <= MAX_L;
    assign accept = in_ready_q && bus.in_valid;
    assign last   = 10'(idx_q) == len_q - 10'd1;
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        case (state_q)
            IDLE, RUN: if (bus.load_start) begin
                if (legal) begin
                    state_d = COLLECT;
                    len_d   = bus.prog_len;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
            COLLECT: if (accept) begin
                word_d = {word_q[23:0], bus.in_byte};
                cnt_d  = cnt_q + 2'd1;
                // 4th byte: latch the write bus now so it is valid during WRITE
                if (cnt_q == 2'd3) begin
                    state_d = WRITE;
                    addr_d  = idx_q;
                    wdat_d  = word_d;
                end
            end
            WRITE: begin
                state_d = last ? RUN : COLLECT;
                idx_d   = last ? idx_q : idx_q + ADDR_W'(1);
            end
        endcase
    end
    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdat_q     <= '0;
            in_ready_q <= 1'b0;
            wen_q      <= 1'b0;
            busy_q     <= 1'b0;
            working_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
            in_ready_q <= state_d == COLLECT;
            wen_q      <= state_d == WRITE;
            busy_q     <= state_d == COLLECT || state_d == WRITE;
            working_q  <= state_d == RUN;
        end
    end
    assign bus.in_ready = in_ready_q;
    assign bus.addr     = addr_q;
    assign bus.wEn      = wen_q;
    assign bus.wDat     = wdat_q;
    assign bus.working  = working_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized program loads against a word-list model; a monitor
// pops expected (addr, data) writes from a scoreboard whenever wEn is seen.
module tb_imem_loader;
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #10 clock = ~clock;

    imem_loader_if #(.ADDR_W(9)) bus();
    imem_loader #(.ADDR_W(9), .MAX_WORDS(512)) dut (
        .clock(clock),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_acc = -1;
    int rise_cyc  = -1;
    logic [8:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    logic [8:0]  last_addr = '0;
    logic [31:0] last_wdat = '0;
    logic        wen_prev = 1'b0;
    logic        work_prev = 1'b0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (!rst_n) begin
            last_addr = '0;
            last_wdat = '0;
            wen_prev  = 1'b0;
            work_prev = 1'b0;
        end else begin
            if (bus.wEn) begin
                check("wEn single-cycle", wen_prev, 0);
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected write: addr=%0h data=%0h, expected no write", bus.addr, bus.wDat);
                end else begin
                    last_addr = exp_addr.pop_front();
                    last_wdat = exp_data.pop_front();
                    check("write addr", bus.addr, last_addr);
                    check("write data", bus.wDat, last_wdat);
                end
            end else begin
                check("addr hold", bus.addr, last_addr);
                check("wDat hold", bus.wDat, last_wdat);
            end
            if (bus.working && !work_prev) rise_cyc = cyc;
            wen_prev  = bus.wEn;
            work_prev = bus.working;
        end
    end

    task automatic start_load(input logic [9:0] len);
        bus.load_start = 1'b1;
        bus.prog_len   = len;
        @(posedge clock); #1;
        bus.load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        @(negedge clock);
        while (!bus.in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("in_ready timeout", bus.in_ready, 1);
        if (first_acc < 0) first_acc = cyc;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gmin, input int gmax);
        for (int k = 3; k >= 0; k--) begin
            repeat ($urandom_range(gmax, gmin)) begin
                @(posedge clock); #1;
            end
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic expect_prog(input logic [31:0] prog[$]);
        foreach (prog[i]) begin
            exp_addr.push_back(9'(i));
            exp_data.push_back(prog[i]);
        end
    endtask

    task automatic feed_prog(input logic [31:0] prog[$], input int gmin, input int gmax, input bit noise);
        foreach (prog[i]) begin
            if (noise && $urandom_range(2, 0) == 0) start_load(10'($urandom_range(512, 1)));
            send_word(prog[i], gmin, gmax);
        end
    endtask

    task automatic wait_working(input int limit);
        int n = 0;
        while (!bus.working && n < limit) begin
            @(negedge clock);
            n++;
        end
        check("working timeout", bus.working, 1);
        @(posedge clock); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p[$];
        bus.load_start = 1'b0;
        bus.prog_len   = '0;
        bus.in_valid   = 1'b0;
        bus.in_byte    = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset addr", bus.addr, 0);
        check("reset wEn", bus.wEn, 0);
        check("reset wDat", bus.wDat, 0);
        check("reset working", bus.working, 0);
        check("reset in_ready", bus.in_ready, 0);
        check("reset busy", bus.busy, 0);
        check("reset err", bus.err, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("idle in_ready", bus.in_ready, 0);

        // Nine-word program, stream held valid
        p = {32'h10f0001c};
        for (int i = 1; i < 8; i++) p.push_back($urandom);
        p.push_back(32'h32450000);
        start_load(10'd9);
        expect_prog(p);
        first_acc = -1;
        feed_prog(p, 0, 0, 0);
        wait_working(100);
        check("nine-word working latency", rise_cyc - first_acc, 45);

        // Throttled single word, 3-cycle gaps
        p = {32'h20100000};
        start_load(10'd1);
        expect_prog(p);
        feed_prog(p, 3, 3, 0);
        wait_working(60);

        // Illegal lengths from RUN
        start_load(10'd0);
        @(negedge clock);
        check("len0 err", bus.err, 1);
        check("len0 busy", bus.busy, 0);
        check("len0 stays in RUN", bus.working, 1);
        @(posedge clock); #1;
        start_load(10'd513);
        repeat (3) @(negedge clock);
        check("len513 err", bus.err, 1);
        check("len513 busy", bus.busy, 0);
        @(posedge clock); #1;
        p = {$urandom};
        start_load(10'd1);
        expect_prog(p);
        @(negedge clock);
        check("legal load clears err", bus.err, 0);
        check("legal load busy", bus.busy, 1);
        @(posedge clock); #1;
        feed_prog(p, 0, 1, 0);
        wait_working(60);

        // Reload from RUN
        p = {$urandom, $urandom};
        start_load(10'd2);
        expect_prog(p);
        @(negedge clock);
        check("reload working drops", bus.working, 0);
        check("reload busy", bus.busy, 1);
        @(posedge clock); #1;
        feed_prog(p, 0, 0, 0);
        wait_working(60);

        // Reset after two bytes of word 3: only words 0..2 get written
        p = {$urandom, $urandom, $urandom, $urandom, $urandom};
        start_load(10'd5);
        for (int i = 0; i < 3; i++) begin
            exp_addr.push_back(9'(i));
            exp_data.push_back(p[i]);
        end
        feed_prog(p[0:2], 0, 0, 0);
        send_byte(p[3][31:24]);
        send_byte(p[3][23:16]);
        rst_n = 1'b0;
        #1;
        check("midload rst addr", bus.addr, 0);
        check("midload rst wEn", bus.wEn, 0);
        check("midload rst wDat", bus.wDat, 0);
        check("midload rst working", bus.working, 0);
        check("midload rst in_ready", bus.in_ready, 0);
        check("midload rst busy", bus.busy, 0);
        check("midload rst err", bus.err, 0);
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'hA5;
        repeat (10) @(negedge clock);
        check("post-reset busy", bus.busy, 0);
        check("post-reset working", bus.working, 0);
        check("post-reset in_ready", bus.in_ready, 0);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;

        // Illegal length from IDLE
        start_load(10'd600);
        @(negedge clock);
        check("idle illegal err", bus.err, 1);
        check("idle illegal busy", bus.busy, 0);
        check("idle illegal working", bus.working, 0);
        @(posedge clock); #1;

        // Random programs with gaps and ignored load_start pulses
        for (int t = 0; t < 4; t++) begin
            p = {};
            repeat ($urandom_range(6, 1)) p.push_back($urandom);
            start_load(10'(p.size()));
            expect_prog(p);
            feed_prog(p, 0, 2, 1);
            wait_working(p.size() * 40 + 20);
        end

        // Full-size program: addresses 0..511, no wrap, no extra write
        p = {};
        repeat (512) p.push_back($urandom);
        start_load(10'd512);
        expect_prog(p);
        first_acc = -1;
        feed_prog(p, 0, 0, 0);
        wait_working(200);
        check("max-len working latency", rise_cyc - first_acc, 2560);
        repeat (5) @(negedge clock);
        check("max-len final addr", bus.addr, 511);
        check("scoreboard drained", exp_addr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 9: instruction-memory address width.
REQ-002 Parameter MAX_WORDS, default 512: largest legal program length in words.
REQ-003 clock  input  1  system clock (50 MHz); all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load_start  input  1  single-cycle request to begin loading a program.
REQ-006 prog_len  input  10  program length in words, sampled when load_start is accepted.
REQ-007 in_valid  input  1  a byte is present on in_byte.
REQ-008 in_byte  input  8  program byte stream, MSB of each word first.
REQ-009 in_ready  output  1  loader can accept a byte this cycle.
REQ-010 addr  output  ADDR_W  instruction-memory write address, to processor addr.
REQ-011 wEn  output  1  instruction-memory write enable, to processor wEn.
REQ-012 wDat  output  32  instruction word, to processor wDat.
REQ-013 working  output  1  processor run enable, to processor working.
REQ-014 busy  output  1  load in progress.
REQ-015 err  output  1  sticky flag for an illegal prog_len request.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, COLLECT, WRITE and RUN; all outputs SHALL be registered.
REQ-017 IDLE: load_start with 1 <= prog_len <= MAX_WORDS SHALL do all of the following on the next edge:
- latch prog_len;
- clear the word index and byte count;
- clear err;
- enter COLLECT.
REQ-018 IDLE or RUN: load_start with prog_len = 0 or prog_len > MAX_WORDS SHALL set err and leave the state unchanged.
REQ-019 In COLLECT, in_ready SHALL be 1; a byte is accepted only when in_valid and in_ready are both 1.
REQ-020 Each accepted byte SHALL shift into a 32-bit assembly register: word = {word[23:0], in_byte}.
REQ-021 On acceptance of the 4th byte of a word, the FSM SHALL enter WRITE on the next edge.
REQ-022 In WRITE, for exactly one cycle, the FSM SHALL drive:
- wEn = 1;
- addr = word index;
- wDat = assembled word;
- in_ready = 0.
REQ-023 After WRITE the word index SHALL increment; the FSM SHALL return to COLLECT if words remain, otherwise enter RUN.
REQ-024 In RUN, working SHALL be 1 and wEn SHALL be 0; RUN SHALL persist until reset or an accepted load_start.
REQ-025 load_start in RUN with a legal prog_len SHALL force working to 0 on the next edge and enter COLLECT from word 0.
REQ-026 load_start asserted in COLLECT or WRITE SHALL be ignored.
REQ-027 busy SHALL be 1 exactly in COLLECT and WRITE.
REQ-028 Outside WRITE, wEn SHALL be 0; addr and wDat SHALL hold their last values.
REQ-029 Gaps in in_valid SHALL stall assembly without losing accepted bytes.
REQ-030 Minimum load time SHALL be 5 cycles per word: 4 accept cycles plus 1 write cycle.
REQ-031 working SHALL rise on the edge after the final WRITE cycle.
REQ-032 The word index SHALL never exceed prog_len-1.
REQ-033 prog_len = MAX_WORDS SHALL write addresses 0 through MAX_WORDS-1 with no wrap and no extra write.

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE and drive all of the following to 0:
- addr, wEn, wDat;
- working, in_ready, busy, err;
- word index, byte count, assembly register.
REQ-035 Reset mid-load SHALL abandon the partial word without issuing a write; after reset release, loading restarts only on a new load_start.

Verification
REQ-036 Nine-word program: load_start, prog_len=9; bytes 10 f0 00 1c ... 32 45 00 00 with in_valid held high:
- writes addr0=0x10f0001c through addr8=0x32450000;
- each write has wEn high for one cycle;
- working rises 45 cycles after the first byte is accepted.
REQ-037 Throttled stream: prog_len=1, bytes 20 10 00 00 with 3-cycle gaps between bytes -> single write addr0=0x20100000; no byte lost; wEn pulses once.
REQ-038 Illegal length: prog_len=0 -> err=1, busy=0. Then prog_len=513 -> err stays 1, no wEn. Then prog_len=1 -> err clears.
REQ-039 Reset mid-load: rst_n low after 2 bytes of word 3 -> all outputs 0 immediately; no write to addr3; no working.
REQ-040 Reload from RUN: load_start, prog_len=2 while working=1:
- working=0 next cycle;
- busy=1;
- writes restart at addr0;
- working returns to 1 after the 2nd write.
